// File: rtl/copy_arb_pkg.sv
// copy_arb_pkg: shared types and helpers for the copy arbiter.
// FSM state encoding, default address width and a one-hot to index helper.
package copy_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Index of the set bit of a one-hot vector of up to 8 bits (0 if none set).
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = 0; i < 8; i++) begin
         idx = idx | ({IDX_W{oh[i]}} & IDX_W'(i));
      end
      return idx;
   endfunction

endpackage

// File: rtl/copy_arbiter_if.sv
// copy_arbiter_if: requester descriptors, grant/done pulses and copier handshake.
// slave modport is the arbiter's view; master is the requester/copier side.
interface copy_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8
) ();
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] src_in;
   logic [NUM_REQ*ADDR_W-1:0] dst_in;
   logic [NUM_REQ*ADDR_W-1:0] size_in;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic                      busy;
   logic                      cp_start;
   logic [ADDR_W-1:0]         cp_src;
   logic [ADDR_W-1:0]         cp_dst;
   logic [ADDR_W-1:0]         cp_size;
   logic                      cp_finished;

   modport slave (
      input  req, src_in, dst_in, size_in, cp_finished,
      output gnt, done, busy, cp_start, cp_src, cp_dst, cp_size
   );

   modport master (
      output req, src_in, dst_in, size_in, cp_finished,
      input  gnt, done, busy, cp_start, cp_src, cp_dst, cp_size
   );
endinterface

// File: rtl/copy_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
// Search starts at rr_ptr and wraps; the first set request wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   // Walk the requests in rotated order and keep only the first hit.
   always_comb begin
      logic found;
      int   idx;
      winner = {NUM_REQ{1'b0}};
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx         = (int'(rr_ptr) + k) % NUM_REQ;
         winner[idx] = ~found & req[idx];
         found       = found | req[idx];
      end
      valid = |req;
   end

endmodule

// File: rtl/copy_arbiter.sv
// copy_arbiter: shares one copier between NUM_REQ requesters.
// Grants round-robin, latches the winning descriptor, runs the copier
// start/finished handshake and pulses done to the owner.
// Build option COPY_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no rotation pointer.
module copy_arbiter
   import copy_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic           CLK,
   input  logic           RST,
   copy_arbiter_if.slave  bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state;
   state_t             next_state;
   logic [NUM_REQ-1:0] winner;
   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   owner;
   logic [ADDR_W-1:0]  src_hold;
   logic [ADDR_W-1:0]  dst_hold;
   logic [ADDR_W-1:0]  size_hold;
   logic [NUM_REQ-1:0] gnt_vec;
   logic [NUM_REQ-1:0] done_vec;
   logic               take;

   assign win_idx = onehot_to_idx(8'(winner));
   assign take    = (state == IDLE) && win_valid;

`ifdef COPY_ARB_FIXED_PRIO_EN
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req    (bus.req),
      .rr_ptr ({PTR_W{1'b0}}),
      .winner (winner),
      .valid  (win_valid)
   );
`else
   logic [PTR_W-1:0] rr_ptr;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .valid  (win_valid)
   );

   // Move the search start just past the requester that was granted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= {PTR_W{1'b0}};
      end else if (take) begin
         if (win_idx == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr <= {PTR_W{1'b0}};
         end else begin
            rr_ptr <= PTR_W'(win_idx + 3'd1);
         end
      end else begin
         rr_ptr <= rr_ptr;
      end
   end
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the combinational grant pulse.
   always_comb begin
      next_state = state;
      gnt_vec    = {NUM_REQ{1'b0}};
      case (state)
         IDLE: begin
            if (win_valid) begin
               gnt_vec    = winner;
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         ISSUE: begin
            if (bus.cp_finished) begin
               next_state = RELEASE;
            end else begin
               next_state = ISSUE;
            end
         end
         RELEASE: begin
            if (!bus.cp_finished) begin
               next_state = DONE;
            end else begin
               next_state = RELEASE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Capture the winner's descriptor; held untouched until the next grant.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner     <= {IDX_W{1'b0}};
         src_hold  <= {ADDR_W{1'b0}};
         dst_hold  <= {ADDR_W{1'b0}};
         size_hold <= {ADDR_W{1'b0}};
      end else if (take) begin
         owner     <= win_idx;
         src_hold  <= bus.src_in[int'(win_idx)*ADDR_W +: ADDR_W];
         dst_hold  <= bus.dst_in[int'(win_idx)*ADDR_W +: ADDR_W];
         size_hold <= bus.size_in[int'(win_idx)*ADDR_W +: ADDR_W];
      end else begin
         owner     <= owner;
         src_hold  <= src_hold;
         dst_hold  <= dst_hold;
         size_hold <= size_hold;
      end
   end

   // Completion pulse to the owner while in DONE.
   always_comb begin
      done_vec = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         done_vec[i] = (state == DONE) && (owner == IDX_W'(i));
      end
   end

   assign bus.gnt      = gnt_vec;
   assign bus.done     = done_vec;
   assign bus.busy     = (state != IDLE);
   assign bus.cp_start = (state == ISSUE);
   assign bus.cp_src   = src_hold;
   assign bus.cp_dst   = dst_hold;
   assign bus.cp_size  = size_hold;

endmodule

// File: doc/copy_arbiter.md
Name: copy_arbiter

Overview:
Shares one copier engine between NUM_REQ requesters, each presenting a copy descriptor (src, dst, size). Arbitrates round-robin and latches the winning descriptor into holding registers. Drives the copier's start/address/size inputs and runs its start/finished handshake to completion. Returns a per-requester done pulse. Sits between the DMA request sources and the copier, on the copier's clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, address and size width (matches copier)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester level request
src_in  input  NUM_REQ*ADDR_W  flattened source addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
dst_in  input  NUM_REQ*ADDR_W  flattened destination addresses, same packing
size_in  input  NUM_REQ*ADDR_W  flattened copy sizes, same packing
gnt  output  NUM_REQ  one-hot grant pulse, 1 cycle, in the descriptor-capture cycle
done  output  NUM_REQ  one-hot completion pulse, 1 cycle
busy  output  1  high whenever state != IDLE
cp_start  output  1  to copier start
cp_src  output  ADDR_W  to copier src_addr, registered
cp_dst  output  ADDR_W  to copier dst_addr, registered
cp_size  output  ADDR_W  to copier copy_size, registered
cp_finished  input  1  from copier finished

Behaviour:
- Reset (RST=1 at edge): state=IDLE; rr_ptr=0; owner=0. cp_start, cp_src, cp_dst, cp_size all 0. gnt, done, busy all 0.
- The copier shares the same reset, inverted at top level. Reset mid-copy aborts both blocks. No done pulse is issued for the aborted job.
- States:
  - IDLE: if any req, select a winner. gnt[w]=1 combinationally this cycle. At the edge, latch src/dst/size of w into the cp_* registers, owner=w, rr_ptr=(w+1) mod NUM_REQ, go to ISSUE. With no req, stay in IDLE.
  - ISSUE: cp_start=1. On cp_finished=1 go to RELEASE.
  - RELEASE: cp_start=0. On cp_finished=0 go to DONE. The copier drops finished one cycle after start falls.
  - DONE: done[owner]=1 for exactly this cycle, then go to IDLE.
- Round-robin: search starts at rr_ptr and wraps from NUM_REQ-1 to 0. The first set req wins.
- Minimum spacing: one gnt per 4 cycles (IDLE, ISSUE, RELEASE, DONE).
- Latency: gnt appears in the same cycle req is seen in IDLE. cp_start rises the next cycle.
- Requester rules:
  - Hold req and the descriptor stable until gnt is seen.
  - req still high after the gnt cycle counts as a new job.
  - Dropping req before gnt withdraws the request with no side effect.
- cp_src, cp_dst and cp_size stay constant from ISSUE through DONE, independent of the *_in inputs.
- size=0: passed through unchanged. The copier finishes immediately and the normal ISSUE, RELEASE, DONE sequence follows.
- Simultaneous req from all requesters: served in rotation starting at rr_ptr. No requester waits more than NUM_REQ grants.
- cp_finished=1 while in IDLE or DONE: ignored.
- State encoding: the default/illegal branch returns to IDLE with cp_start=0.

Optional Feature:
COPY_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. rr_ptr is removed, and starvation of high indices is permitted.
- Undefined (default): round-robin as above.
- All ports are identical in both builds.

Decomposition:
- Package copy_arb_pkg:
  - state enum (IDLE, ISSUE, RELEASE, DONE) as 2 bits
  - ADDR_W default constant
  - function onehot_to_idx
- Sub-module rr_arbiter (NUM_REQ): inputs req and rr_ptr; outputs one-hot winner and valid. Purely combinational.
- copy_arbiter owns the pointer register and honours the macro.

Test Plan:
- Single req[1] with src=0x10, dst=0x80, size=4, copier model answering → gnt[1] at cycle 0; cp_start cycle 1; cp_src=0x10, cp_dst=0x80, cp_size=4 held; done[1] exactly once; busy low after DONE.
- req=4'b1111 held continuously → grant order 0,1,2,3,0; done order matches; gnt spacing ≥4 cycles.
- req[2] with size=0 → copier finishes immediately; cp_start high 1 cycle then low; done[2] pulses; no hang.
- Change src_in[2] to 0xFF during ISSUE → cp_src keeps the latched value; copier writes the original range only.
- Assert RST during ISSUE → next cycle cp_start=0, busy=0, no done pulse; a following req[3] is granted with rr_ptr=0 ordering.
- Build with COPY_ARB_FIXED_PRIO_EN and req=4'b1010 held → req[1] granted repeatedly, req[3] never granted while req[1] stays high.
